// File: rtl/product_accumulator.sv
// Sums a flagged sequence of multiplier products into a wide accumulator and
// offers the total, product count and sticky wrap flag through a valid/ready handshake.
module product_accumulator #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_product,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_overflow
);

    localparam int SUM_WIDTH = ACC_WIDTH + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_ovf;
    logic [ACC_WIDTH-1:0] r_outSum;
    logic [CNT_WIDTH-1:0] r_outCount;
    logic                 r_outOvf;

    logic                 w_xfer;
    logic                 w_handshake;
    logic [SUM_WIDTH-1:0] w_sumWide;
    logic [ACC_WIDTH-1:0] w_newAcc;
    logic [CNT_WIDTH-1:0] w_newCnt;
    logic                 w_newOvf;

    // The carry out of the widened sum is what marks a wrap of the accumulator.
    assign w_sumWide   = {1'b0, r_acc} + SUM_WIDTH'(in_product);
    assign w_newAcc    = w_sumWide[ACC_WIDTH-1:0];
    assign w_newOvf    = r_ovf | w_sumWide[ACC_WIDTH];
    assign w_newCnt    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_WIDTH'(1);
    assign w_xfer      = in_valid & in_ready;
    assign w_handshake = out_valid & out_ready;

    assign out_sum      = r_outSum;
    assign out_count    = r_outCount;
    assign out_overflow = r_outOvf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Handshake outputs depend only on state, never on in_valid or out_ready.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = ACCUM;
                end
            end
            default: begin
                w_nextState = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_outSum   <= '0;
            r_outCount <= '0;
            r_outOvf   <= 1'b0;
        end else if (w_handshake) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_xfer) begin
            r_acc <= w_newAcc;
            r_cnt <= w_newCnt;
            r_ovf <= w_newOvf;
            // The completing product is already folded into the published result.
            if (in_last) begin
                r_outSum   <= w_newAcc;
                r_outCount <= w_newCnt;
                r_outOvf   <= w_newOvf;
            end
        end
    end

endmodule
